cache_bus_arbiter: RTL and testbench
====================================

Name: cache_bus_arbiter

Overview:
- Arbiter-side responder for the cache request/response protocol.
- Accepts line requests from the I-cache and the D-cache through two arbiter-role interface ports.
- Forwards exactly one transaction at a time to the upstream system bus, which uses the same protocol with this block in the cache role.
- Routes response beats back to the owning cache.

Parameters:
- DATA_WIDTH, 64, width of the req/resp payload (address or data beat).
- TAG_WIDTH, 13, width of reqtag/resptag.
- BEATS, 8, data beats per line transfer (write data beats or read response beats).

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- icache  ArbiterCacheInterface.ArbiterPorts  bundle  I-cache side; this block responds.
- dcache  ArbiterCacheInterface.ArbiterPorts  bundle  D-cache side; this block responds.
- bus  ArbiterCacheInterface.CachePorts  bundle  upstream system bus; this block initiates.

Behaviour:
- Tag layout (shared package):
  - bit 12 = READ(1)/WRITE(0).
  - bits 11:8 = type (MEMORY 0001, MMIO 0011, PORT 0100, IRQ 1110).
  - bit 7 = INST(1)/DATA(0).
  - bits 6:0 pass through unchanged.
- FSM states: IDLE, ADDR, WDATA, RESP.
- Registered state: state, owner (0=I, 1=D), rr pointer, beat counter (clog2(BEATS+1) bits).
- All outputs are combinational from registered state plus forwarded inputs. Every output not listed as forwarded in the current state is 0.
- Reset (reset==0, async): state=IDLE, owner=D, rr pointer=D (D-cache wins first tie), counter=0. All outputs 0 the same instant.
- Reset mid-transaction abandons it: no further acks, and bus.reqcyc/bus.respack drop immediately.
- IDLE:
  - Sample icache.reqcyc and dcache.reqcyc.
  - One requester: it wins. Both: winner = rr pointer. Neither: stay in IDLE.
  - On a grant: owner<=winner, rr pointer<=other port, state<=ADDR.
  - No acks are issued in IDLE, so there is one arbitration cycle minimum before every transaction.
- ADDR:
  - bus.req, bus.reqtag and bus.reqcyc are forwarded from the owner's req, reqtag and reqcyc.
  - owner.reqack = bus.reqack, combinational pass-through in the same cycle. The non-owner reqack is 0.
  - On bus.reqack with reqtag[12]==WRITE: counter<=0, state<=WDATA.
  - On bus.reqack with reqtag[12]==READ: counter<=0, state<=RESP.
  - If the owner drops reqcyc before the ack: state<=IDLE, nothing is issued.
- WDATA:
  - Forward the owner's req and reqcyc to the bus. reqtag is forwarded unchanged.
  - owner.reqack = bus.reqack.
  - Each acked beat: counter++.
  - When the BEATS-th beat is acked: state<=IDLE. Writes get no response.
- RESP:
  - owner.resp, resptag and respcyc are forwarded from the bus. The non-owner sees respcyc=0 and resp=0.
  - bus.respack = owner.respack & bus.respcyc.
  - Each beat with respcyc&respack: counter++.
  - When the BEATS-th beat is acked: state<=IDLE.
- bus.respcyc outside RESP is ignored: bus.respack=0 and nothing is routed.
- A non-owner request stays pending (no reqack) until the arbiter returns to IDLE. It then wins if it is the sole requester or the rr pointer favours it.
- A starvation bound follows from round-robin: with both caches requesting continuously, grants alternate I/D/I/D after the first D.
- The counter never exceeds BEATS and wraps to 0 on every new transaction.
- The FSM never leaves WDATA/RESP early: with BEATS=8, exactly 8 acked beats are required.

Decomposition:
- Package cache_bus_pkg holds:
  - tag field bit positions;
  - READ/WRITE, the type codes and INST/DATA constants;
  - the FSM state enum;
  - the owner encoding.
- Sub-module rr_arbiter2 holds the 2-way round-robin grant and pointer register (reset to D, advances only on grant).
- The top level holds the FSM, the counter and the muxing.

Test Plan:
- Single I-cache read: icache.reqcyc=1, reqtag={1,0001,1,0x00}, req=0x1000.
  - Required: bus.reqcyc rises the cycle after the request, with the same req/tag.
  - Required: icache.reqack pulses with bus.reqack.
  - Required: 8 bus response beats D0..D7 appear on icache.resp in order; dcache.respcyc stays 0; the FSM returns to IDLE after the 8th respack.
- D-cache write: reqtag={0,0001,0,..}, address 0x2000, then 8 data beats 0xA0..0xA7.
  - Required: the bus sees the address plus 8 beats, each acked back to dcache.
  - Required: no RESP state is entered; IDLE follows the 8th ack.
- Simultaneous requests from reset (both reqcyc=1 held):
  - Required: grant order D, I, D, I over four reads.
  - Required: the losing cache's reqack stays 0 until it is granted.
- Backpressure: the cache deasserts respack for 3 cycles mid-read at beat 4.
  - Required: bus.respack=0 for those cycles and the counter holds at 4.
  - Required: exactly 8 beats are delivered in total.
- Reset pulse (reset=0 for 1 cycle) during WDATA beat 3:
  - Required: all outputs 0 immediately and state IDLE.
  - Required: the next transaction is granted to D if both caches request.
- Spurious bus.respcyc=1 while in IDLE:
  - Required: bus.respack=0 and both caches' respcyc=0.

Source files
------------

// File: rtl/cache_bus_pkg.sv
// Shared tag layout, field codes, FSM state and owner encodings for the
// cache request/response protocol.
package cache_bus_pkg;

  localparam int TAG_W       = 13;
  localparam int TAG_RW_BIT  = 12;
  localparam int TAG_TYPE_HI = 11;
  localparam int TAG_TYPE_LO = 8;
  localparam int TAG_INST_BIT = 7;

  localparam logic TAG_READ  = 1'b1;
  localparam logic TAG_WRITE = 1'b0;

  localparam logic [3:0] TYPE_MEMORY = 4'b0001;
  localparam logic [3:0] TYPE_MMIO   = 4'b0011;
  localparam logic [3:0] TYPE_PORT   = 4'b0100;
  localparam logic [3:0] TYPE_IRQ    = 4'b1110;

  localparam logic TAG_INST = 1'b1;
  localparam logic TAG_DATA = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ADDR  = 2'd1,
    ST_WDATA = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  typedef enum logic {
    OWNER_I = 1'b0,
    OWNER_D = 1'b1
  } owner_t;

  function automatic logic tag_is_read(input logic [TAG_W-1:0] tag);
    return tag[TAG_RW_BIT] == TAG_READ;
  endfunction

  function automatic logic [TAG_W-1:0] make_tag(input logic rw, input logic [3:0] typ,
                                                input logic inst, input logic [6:0] low);
    logic [TAG_W-1:0] tag;
    tag = '0;
    tag[TAG_RW_BIT] = rw;
    tag[TAG_TYPE_HI:TAG_TYPE_LO] = typ;
    tag[TAG_INST_BIT] = inst;
    tag[6:0] = low;
    return tag;
  endfunction

endpackage

// File: rtl/cache_bus_arbiter_if.sv
// Request/response bundle; the cache role drives the request channel and
// the response handshake, the arbiter role answers.
interface ArbiterCacheInterface #(
  parameter int DATA_WIDTH = 64,
  parameter int TAG_WIDTH  = 13
);
  logic [DATA_WIDTH-1:0] req;
  logic [TAG_WIDTH-1:0]  reqtag;
  logic                  reqcyc;
  logic                  reqack;
  logic [DATA_WIDTH-1:0] resp;
  logic [TAG_WIDTH-1:0]  resptag;
  logic                  respcyc;
  logic                  respack;

  modport ArbiterPorts (
    input  req, reqtag, reqcyc, respack,
    output reqack, resp, resptag, respcyc
  );

  modport CachePorts (
    output req, reqtag, reqcyc, respack,
    input  reqack, resp, resptag, respcyc
  );
endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant: the pointer names the port that wins a tie and
// moves to the loser only when a grant is actually taken.
module rr_arbiter2
  import cache_bus_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   req_i,
  input  logic   req_d,
  input  logic   advance,
  output logic   grant_valid,
  output owner_t winner
);

  owner_t ptr_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_reg <= OWNER_D;
    end else if (advance && grant_valid) begin
      ptr_reg <= (winner == OWNER_D) ? OWNER_I : OWNER_D;
    end
  end

  always_comb begin
    grant_valid = req_i | req_d;
    if (req_i && req_d) begin
      winner = ptr_reg;
    end else if (req_i) begin
      winner = OWNER_I;
    end else begin
      winner = OWNER_D;
    end
  end

endmodule

// File: rtl/cache_bus_arbiter.sv
// Arbitrates I-cache and D-cache line requests onto one upstream bus, one
// transaction at a time, and routes response beats back to the owner.
module cache_bus_arbiter
  import cache_bus_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int TAG_WIDTH  = 13,
  parameter int BEATS      = 8
) (
  input logic                        clk,
  input logic                        reset,
  ArbiterCacheInterface.ArbiterPorts icache,
  ArbiterCacheInterface.ArbiterPorts dcache,
  ArbiterCacheInterface.CachePorts   bus
);

  localparam int CNT_W = $clog2(BEATS + 1);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  state_t           state_reg, state_next;
  owner_t           owner_reg, owner_next;
  logic [CNT_W-1:0] count_reg, count_next;

  logic                  grant_valid;
  owner_t                winner;
  logic [DATA_WIDTH-1:0] own_req;
  logic [TAG_WIDTH-1:0]  own_tag;
  logic                  own_cyc;
  logic                  own_respack;
  logic                  req_beat;
  logic                  resp_beat;
  logic                  fwd_req;
  logic                  fwd_resp;
  logic                  sel_i;
  logic                  sel_d;

  rr_arbiter2 u_rr (
    .clk         (clk),
    .reset       (reset),
    .req_i       (icache.reqcyc),
    .req_d       (dcache.reqcyc),
    .advance     (state_reg == ST_IDLE),
    .grant_valid (grant_valid),
    .winner      (winner)
  );

  assign own_req     = (owner_reg == OWNER_D) ? dcache.req     : icache.req;
  assign own_tag     = (owner_reg == OWNER_D) ? dcache.reqtag  : icache.reqtag;
  assign own_cyc     = (owner_reg == OWNER_D) ? dcache.reqcyc  : icache.reqcyc;
  assign own_respack = (owner_reg == OWNER_D) ? dcache.respack : icache.respack;

  // A beat only counts when it was actually offered and accepted.
  assign req_beat  = own_cyc & bus.reqack;
  assign resp_beat = bus.respcyc & own_respack;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= ST_IDLE;
      owner_reg <= OWNER_D;
      count_reg <= '0;
    end else begin
      state_reg <= state_next;
      owner_reg <= owner_next;
      count_reg <= count_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    owner_next = owner_reg;
    count_next = count_reg;
    case (state_reg)
      ST_IDLE: begin
        if (grant_valid) begin
          owner_next = winner;
          state_next = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (req_beat) begin
          count_next = '0;
          state_next = tag_is_read(own_tag) ? ST_RESP : ST_WDATA;
        end else if (!own_cyc) begin
          state_next = ST_IDLE;
        end
      end
      ST_WDATA: begin
        if (req_beat) begin
          count_next = count_reg + CNT_W'(1);
          if (count_reg == LAST_BEAT) state_next = ST_IDLE;
        end
      end
      ST_RESP: begin
        if (resp_beat) begin
          count_next = count_reg + CNT_W'(1);
          if (count_reg == LAST_BEAT) state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Address and write-data phases look identical on the wires.
  always_comb begin
    fwd_req  = (state_reg == ST_ADDR) || (state_reg == ST_WDATA);
    fwd_resp = (state_reg == ST_RESP);
    sel_i    = owner_reg == OWNER_I;
    sel_d    = owner_reg == OWNER_D;
  end

  assign bus.req     = fwd_req ? own_req : '0;
  assign bus.reqtag  = fwd_req ? own_tag : '0;
  assign bus.reqcyc  = fwd_req & own_cyc;
  assign bus.respack = fwd_resp & own_respack & bus.respcyc;

  assign icache.reqack  = fwd_req & sel_i & bus.reqack;
  assign icache.resp    = (fwd_resp && sel_i) ? bus.resp    : '0;
  assign icache.resptag = (fwd_resp && sel_i) ? bus.resptag : '0;
  assign icache.respcyc = fwd_resp & sel_i & bus.respcyc;

  assign dcache.reqack  = fwd_req & sel_d & bus.reqack;
  assign dcache.resp    = (fwd_resp && sel_d) ? bus.resp    : '0;
  assign dcache.resptag = (fwd_resp && sel_d) ? bus.resptag : '0;
  assign dcache.respcyc = fwd_resp & sel_d & bus.respcyc;

endmodule

// File: tb/tb_cache_bus_arbiter.sv
// Bench for cache_bus_arbiter: directed scenarios plus random traffic, all
// checked each cycle against a transaction-level model of the arbiter.
module tb_cache_bus_arbiter;
  import cache_bus_pkg::*;

  localparam int DW = 64;
  localparam int TW = 13;
  localparam int NB = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  ArbiterCacheInterface #(.DATA_WIDTH(DW), .TAG_WIDTH(TW)) ic_if ();
  ArbiterCacheInterface #(.DATA_WIDTH(DW), .TAG_WIDTH(TW)) dc_if ();
  ArbiterCacheInterface #(.DATA_WIDTH(DW), .TAG_WIDTH(TW)) bus_if ();

  cache_bus_arbiter #(.DATA_WIDTH(DW), .TAG_WIDTH(TW), .BEATS(NB)) dut (
    .clk    (clk),
    .reset  (reset),
    .icache (ic_if),
    .dcache (dc_if),
    .bus    (bus_if)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Transaction-level model: at most one open transaction plus who wins a tie.
  typedef struct {
    bit busy;
    bit owner_d;
    bit addr_done;
    bit is_read;
    int beats;
  } txn_t;

  txn_t cur = '{0, 0, 0, 0, 0};
  bit   favour_d = 1'b1;
  bit   grant_log[$];

  always @(posedge clk) begin : model_update
    bit w;
    bit o_cyc;
    bit o_rak;
    logic [TW-1:0] o_tag;
    o_cyc = cur.owner_d ? dc_if.reqcyc  : ic_if.reqcyc;
    o_rak = cur.owner_d ? dc_if.respack : ic_if.respack;
    o_tag = cur.owner_d ? dc_if.reqtag  : ic_if.reqtag;
    if (!reset) begin
      cur.busy = 1'b0;
      favour_d = 1'b1;
    end else if (!cur.busy) begin
      if (ic_if.reqcyc || dc_if.reqcyc) begin
        w = (ic_if.reqcyc && dc_if.reqcyc) ? favour_d : dc_if.reqcyc;
        favour_d = !w;
        cur = '{1'b1, w, 1'b0, 1'b0, 0};
        grant_log.push_back(w);
      end
    end else if (!cur.addr_done) begin
      if (o_cyc && bus_if.reqack) begin
        cur.addr_done = 1'b1;
        cur.is_read = o_tag[12];
        cur.beats = 0;
      end else if (!o_cyc) begin
        cur.busy = 1'b0;
      end
    end else begin
      if (cur.is_read ? (bus_if.respcyc && o_rak) : (o_cyc && bus_if.reqack)) cur.beats++;
      if (cur.beats == NB) cur.busy = 1'b0;
    end
  end

  always @(negedge clk) begin : compare
    logic [127:0] e_ic, e_dc, e_bus, e_own;
    logic o_cyc, o_rak;
    logic [TW-1:0] o_tag;
    logic [DW-1:0] o_req;
    #2;
    e_ic = '0; e_dc = '0; e_bus = '0; e_own = '0;
    o_cyc = cur.owner_d ? dc_if.reqcyc  : ic_if.reqcyc;
    o_rak = cur.owner_d ? dc_if.respack : ic_if.respack;
    o_tag = cur.owner_d ? dc_if.reqtag  : ic_if.reqtag;
    o_req = cur.owner_d ? dc_if.req     : ic_if.req;
    if (reset && cur.busy) begin
      if (!cur.addr_done || !cur.is_read) begin
        e_bus = 128'({o_cyc, 1'b0, o_tag, o_req});
        e_own = 128'({bus_if.reqack, 1'b0, {TW{1'b0}}, {DW{1'b0}}});
      end else begin
        e_bus = 128'({1'b0, o_rak & bus_if.respcyc, {TW{1'b0}}, {DW{1'b0}}});
        e_own = 128'({1'b0, bus_if.respcyc, bus_if.resptag, bus_if.resp});
      end
      if (cur.owner_d) e_dc = e_own; else e_ic = e_own;
    end
    chk("icache_outs", 128'({ic_if.reqack, ic_if.respcyc, ic_if.resptag, ic_if.resp}), e_ic);
    chk("dcache_outs", 128'({dc_if.reqack, dc_if.respcyc, dc_if.resptag, dc_if.resp}), e_dc);
    chk("bus_outs", 128'({bus_if.reqcyc, bus_if.respack, bus_if.reqtag, bus_if.req}), e_bus);
  end

  task automatic next();
    @(negedge clk);
    #1;
  endtask

  task automatic clear();
    ic_if.req = '0; ic_if.reqtag = '0; ic_if.reqcyc = 1'b0; ic_if.respack = 1'b0;
    dc_if.req = '0; dc_if.reqtag = '0; dc_if.reqcyc = 1'b0; dc_if.respack = 1'b0;
    bus_if.reqack = 1'b0; bus_if.resp = '0; bus_if.resptag = '0; bus_if.respcyc = 1'b0;
  endtask

  initial begin : stim
    logic [TW-1:0] tag_ir, tag_dw, tag_dr;
    logic [DW-1:0] v;
    logic [3:0]    lg;
    logic [3:0]    types [4];
    int            delivered;
    tag_ir = make_tag(TAG_READ, TYPE_MEMORY, TAG_INST, 7'h00);
    tag_dw = make_tag(TAG_WRITE, TYPE_MEMORY, TAG_DATA, 7'h05);
    tag_dr = make_tag(TAG_READ, TYPE_MEMORY, TAG_DATA, 7'h00);
    types = '{TYPE_MEMORY, TYPE_MMIO, TYPE_PORT, TYPE_IRQ};
    clear();
    #1 reset = 1'b0;
    next();
    #2;
    chk("reset_bus_reqcyc", 128'(bus_if.reqcyc), 128'(1'b0));
    chk("reset_state", 128'(dut.state_reg), 128'(ST_IDLE));
    next();
    reset = 1'b1;

    // Single I-cache read
    next();
    ic_if.reqcyc = 1'b1; ic_if.reqtag = tag_ir; ic_if.req = 64'h1000;
    next();
    bus_if.reqack = 1'b1;
    #2;
    chk("t1_addr", 128'({bus_if.reqcyc, bus_if.reqtag, bus_if.req}), 128'({1'b1, 13'h1180, 64'h1000}));
    chk("t1_reqack", 128'({ic_if.reqack, dc_if.reqack}), 128'(2'b10));
    next();
    ic_if.reqcyc = 1'b0; bus_if.reqack = 1'b0; ic_if.respack = 1'b1;
    for (int k = 0; k < NB; k++) begin
      v = 64'hD0 + 64'(k);
      bus_if.respcyc = 1'b1; bus_if.resp = v; bus_if.resptag = tag_ir;
      #2;
      chk("t1_beat", 128'({ic_if.respcyc, dc_if.respcyc, ic_if.resp}), 128'({2'b10, v}));
      next();
    end
    clear();
    #2;
    chk("t1_idle", 128'(dut.state_reg), 128'(ST_IDLE));

    // D-cache write
    dc_if.reqcyc = 1'b1; dc_if.reqtag = tag_dw; dc_if.req = 64'h2000;
    next();
    bus_if.reqack = 1'b1;
    #2;
    chk("t2_addr", 128'({bus_if.reqcyc, bus_if.reqtag, bus_if.req}), 128'({1'b1, 13'h0105, 64'h2000}));
    chk("t2_addr_ack", 128'({ic_if.reqack, dc_if.reqack}), 128'(2'b01));
    next();
    for (int k = 0; k < NB; k++) begin
      v = 64'hA0 + 64'(k);
      dc_if.req = v;
      #2;
      chk("t2_beat", 128'({bus_if.req, dc_if.reqack}), 128'({v, 1'b1}));
      chk("t2_state", 128'(dut.state_reg), 128'(ST_WDATA));
      next();
    end
    clear();
    #2;
    chk("t2_idle", 128'(dut.state_reg), 128'(ST_IDLE));

    // Simultaneous requests from reset
    reset = 1'b0;
    next();
    reset = 1'b1;
    grant_log.delete();
    for (int t = 0; t < 4; t++) begin
      ic_if.reqcyc = 1'b1; ic_if.reqtag = tag_ir; ic_if.req = 64'h3000 + 64'(t);
      dc_if.reqcyc = 1'b1; dc_if.reqtag = tag_dr; dc_if.req = 64'h4000 + 64'(t);
      next();
      bus_if.reqack = 1'b1;
      #2;
      chk("t3_grant", 128'({ic_if.reqack, dc_if.reqack}), 128'((t % 2 == 0) ? 2'b01 : 2'b10));
      next();
      bus_if.reqack = 1'b0; ic_if.respack = 1'b1; dc_if.respack = 1'b1;
      for (int k = 0; k < NB; k++) begin
        bus_if.respcyc = 1'b1; bus_if.resp = 64'(k);
        next();
      end
      bus_if.respcyc = 1'b0;
    end
    clear();
    lg = '0;
    for (int i = 0; i < grant_log.size() && i < 4; i++) lg[3-i] = grant_log[i];
    chk("t3_log_len", 128'(grant_log.size()), 128'(4));
    chk("t3_log_order", 128'(lg), 128'(4'b1010));

    // Backpressure at beat 4
    ic_if.reqcyc = 1'b1; ic_if.reqtag = tag_ir; ic_if.req = 64'h5000;
    next();
    bus_if.reqack = 1'b1;
    next();
    ic_if.reqcyc = 1'b0; bus_if.reqack = 1'b0;
    delivered = 0;
    for (int c = 0; c < 12; c++) begin
      bus_if.respcyc = 1'b1; bus_if.resp = 64'h100 + 64'(c);
      ic_if.respack = !(c >= 4 && c <= 6);
      #2;
      if (c >= 4 && c <= 6) begin
        chk("t4_hold_respack", 128'(bus_if.respack), 128'(1'b0));
        chk("t4_hold_count", 128'(dut.count_reg), 128'(4));
      end
      if (ic_if.respcyc && ic_if.respack) delivered++;
      next();
    end
    chk("t4_delivered", 128'(delivered), 128'(8));
    chk("t4_idle", 128'(dut.state_reg), 128'(ST_IDLE));
    clear();

    // Reset pulse during write beat 3
    dc_if.reqcyc = 1'b1; dc_if.reqtag = tag_dw; dc_if.req = 64'h2000;
    next();
    bus_if.reqack = 1'b1;
    next();
    for (int k = 0; k < 3; k++) begin
      dc_if.req = 64'hA0 + 64'(k);
      next();
    end
    chk("t5_count", 128'(dut.count_reg), 128'(3));
    dc_if.req = 64'hA3;
    reset = 1'b0;
    #2;
    chk("t5_outs_zero", 128'({bus_if.reqcyc, bus_if.req, dc_if.reqack, bus_if.respack}), 128'(0));
    chk("t5_state", 128'(dut.state_reg), 128'(ST_IDLE));
    next();
    reset = 1'b1; bus_if.reqack = 1'b0;
    ic_if.reqcyc = 1'b1; ic_if.reqtag = tag_ir;
    next();
    #2;
    chk("t5_grant_d", 128'({bus_if.reqcyc, bus_if.reqtag}), 128'({1'b1, 13'h0105}));
    clear();
    next();
    #2;
    chk("t5_abort_idle", 128'(dut.state_reg), 128'(ST_IDLE));

    // Spurious bus response while idle
    bus_if.respcyc = 1'b1; bus_if.resp = 64'hDEAD; bus_if.resptag = 13'h1FFF;
    ic_if.respack = 1'b1; dc_if.respack = 1'b1;
    #2;
    chk("t6_spurious", 128'({bus_if.respack, ic_if.respcyc, dc_if.respcyc}), 128'(3'b000));
    next();
    clear();

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      reset = ($urandom_range(0, 299) != 0);
      ic_if.reqcyc = ($urandom_range(0, 3) != 0);
      ic_if.reqtag = make_tag(1'($urandom_range(0, 1)), types[$urandom_range(0, 3)], TAG_INST, 7'($urandom));
      ic_if.req = {$urandom(), $urandom()};
      ic_if.respack = ($urandom_range(0, 3) != 0);
      dc_if.reqcyc = ($urandom_range(0, 3) != 0);
      dc_if.reqtag = make_tag(1'($urandom_range(0, 1)), types[$urandom_range(0, 3)], TAG_DATA, 7'($urandom));
      dc_if.req = {$urandom(), $urandom()};
      dc_if.respack = ($urandom_range(0, 3) != 0);
      bus_if.reqack = 1'($urandom_range(0, 1));
      bus_if.respcyc = 1'($urandom_range(0, 1));
      bus_if.resp = {$urandom(), $urandom()};
      bus_if.resptag = TW'($urandom);
      next();
    end
    clear();
    reset = 1'b1;
    next();
    next();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
